// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and constant helpers for seq_int_div.
package div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
   localparam int XLEN_DEF = 64;
   localparam int MAXW = 128;
   function automatic logic [MAXW-1:0] min_val(input int w);
      logic [MAXW-1:0] one;
      one = 1;
      return one << (w - 1);
   endfunction
   function automatic logic [MAXW-1:0] ones_val(input int w);
      logic [MAXW-1:0] one;
      one = 1;
      return (one << w) - one;
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step; shifts the next dividend bit into the partial remainder and subtracts the divisor when it fits.
module div_step #(
   parameter int W = 64
) (
   input  logic [W-1:0] r_i,
   input  logic         q_msb_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] r_o,
   output logic         q_bit_o
);
   logic [W:0] r_sh;
   always_comb begin
      r_sh    = {r_i, q_msb_i};
      q_bit_o = r_sh >= {1'b0, b_i};
      // true difference is below b, so modulo-2^W subtraction yields the exact remainder
      r_o     = r_sh[W-1:0] - (q_bit_o ? b_i : '0);
   end
endmodule

// File: rtl/seq_int_div.sv
// seq_int_div: iterative radix-2 restoring divider with RISC-V M-extension semantics.
// DIV_EARLY_OUT_EN: finish in one step when |dividend| < |divisor|.
module seq_int_div
   import div_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic            is_signed,
   output logic            busy,
   output logic            ready,
   output logic [XLEN-1:0] quo,
   output logic [XLEN-1:0] rem
);
   localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
   localparam logic [MAXW-1:0] MIN_W  = min_val(XLEN);
   localparam logic [MAXW-1:0] ONES_W = ones_val(XLEN);
   localparam logic [XLEN-1:0] MIN    = MIN_W[XLEN-1:0];
   localparam logic [XLEN-1:0] ONES   = ONES_W[XLEN-1:0];
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   state_e state_q, state_d;
   logic [XLEN-1:0] r_q, r_d, q_q, q_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, spc_q, spc_d, ready_q, ready_d;
   logic sa, sb, div0, ovf, step_q;
   logic [XLEN-1:0] a_abs, b_abs, step_r;
   div_step #(.W(XLEN)) u_step (
      .r_i(r_q), .q_msb_i(q_q[XLEN-1]), .b_i(b_q), .r_o(step_r), .q_bit_o(step_q)
   );
   always_comb begin
      sa    = is_signed & op1[XLEN-1];
      sb    = is_signed & op2[XLEN-1];
      a_abs = sa ? -op1 : op1;
      b_abs = sb ? -op2 : op2;
      div0  = op2 == '0;
      ovf   = is_signed && op1 == MIN && op2 == ONES;
      state_d   = state_q;
      r_d       = r_q;
      q_d       = q_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      spc_d     = spc_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      ready_d   = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            b_d       = b_abs;
            neg_quo_d = sa ^ sb;
            neg_rem_d = sa;
            spc_d     = div0 | ovf;
            cnt_d     = CW'(XLEN - 1);
            if (div0 | ovf) begin
               state_d = FIX;
               q_d     = div0 ? ONES : MIN;
               r_d     = div0 ? op1 : '0;
            end else if (EARLY && a_abs < b_abs) begin
               state_d = FIX;
               q_d     = '0;
               r_d     = a_abs;
            end else begin
               state_d = CALC;
               q_d     = a_abs;
               r_d     = '0;
            end
         end
         CALC: begin
            r_d     = step_r;
            q_d     = {q_q[XLEN-2:0], step_q};
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == '0) ? FIX : CALC;
         end
         FIX: begin
            quo_d   = (!spc_q && neg_quo_q) ? -q_q : q_q;
            rem_d   = (!spc_q && neg_rem_q) ? -r_q : r_q;
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         r_q       <= '0;
         q_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         spc_q     <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         q_q       <= q_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         spc_q     <= spc_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         ready_q   <= ready_d;
      end
   end
   assign busy  = state_q != IDLE;
   assign ready = ready_q;
   assign quo   = quo_q;
   assign rem   = rem_q;
endmodule

// File: tb/tb_seq_int_div.sv
// tb_seq_int_div: directed self-checking bench for seq_int_div at XLEN=64.
module tb_seq_int_div;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, is_signed = 1'b0;
   logic [63:0] op1 = '0, op2 = '0;
   logic busy, ready;
   logic [63:0] quo, rem;
   int checks = 0, failures = 0, lat, bc;
   localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DIV_EARLY_OUT_EN
   localparam int EO = 1;
`else
   localparam int EO = 65;
`endif
   seq_int_div #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2), .is_signed(is_signed),
      .busy(busy), .ready(ready), .quo(quo), .rem(rem)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wait_ready();
      lat = 0;
      bc = busy ? 1 : 0;
      while (!ready && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) bc++;
      end
   endtask
   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
      op1 = a;
      op2 = b;
      is_signed = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op1 = ONES;
      op2 = 64'd3;
      is_signed = ~s;
   endtask
   task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s,
                      input int elat, input logic [63:0] eq, input logic [63:0] er);
      issue(a, b, s);
      wait_ready();
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
      chk({tag, "_quo"}, quo, eq);
      chk({tag, "_rem"}, rem, er);
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_quo", quo, 64'd0);
      chk("rst_rem", rem, 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      run("u100_7", 64'd100, 64'd7, 1'b0, 65, 64'd14, 64'd2);
      chk("u100_7_busy", 64'(bc), 64'd65);
      @(posedge clk);
      #1;
      chk("ready_pulse", 64'(ready), 64'd0);
      chk("quo_hold", quo, 64'd14);
      run("sm7_2", -64'sd7, 64'd2, 1'b1, 65, -64'sd3, ONES);
      run("s7_m2", 64'd7, -64'sd2, 1'b1, 65, -64'sd3, 64'd1);
      run("u_div0", 64'h1234, 64'd0, 1'b0, 1, ONES, 64'h1234);
      run("s_div0", 64'h1234, 64'd0, 1'b1, 1, ONES, 64'h1234);
      run("s_ovf", MIN, ONES, 1'b1, 1, MIN, 64'd0);
      run("u_min_ones", MIN, ONES, 1'b0, EO, 64'd0, MIN);
      issue(64'd1000, 64'd10, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      op1 = 64'd50;
      op2 = 64'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_ready();
      chk("ign_lat", 64'(lat), 64'd55);
      chk("ign_quo", quo, 64'd100);
      chk("ign_rem", rem, 64'd0);
      op1 = 64'd81;
      op2 = 64'd9;
      is_signed = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("coin_busy", 64'(busy), 64'd1);
      chk("coin_hold", quo, 64'd100);
      wait_ready();
      chk("coin_lat", 64'(lat), 64'd65);
      chk("coin_quo", quo, 64'd9);
      chk("coin_rem", rem, 64'd0);
      issue(64'd100, 64'd7, 1'b0);
      repeat (29) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_quo", quo, 64'd0);
      chk("mid_rst_rem", rem, 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      bc = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (ready) bc++;
      end
      rst = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready) bc++;
      end
      chk("mid_rst_noready", 64'(bc), 64'd0);
      run("u9_3", 64'd9, 64'd3, 1'b0, 65, 64'd3, 64'd0);
      run("u5_9", 64'd5, 64'd9, 1'b0, EO, 64'd0, 64'd5);
      run("sm5_9", -64'sd5, 64'd9, 1'b1, EO, 64'd0, -64'sd5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
